bus_interface_unit: RTL
=======================

BUS_INTERFACE_UNIT -- requirements
Module: bus_interface_unit

Interface
REQ-001 SETUP_CYCLES, default 1: address-setup cycles before the strobe; must be at least 1.
REQ-002 STROBE_CYCLES, default 2: minimum cycles rd/wr is high; must be at least 1.
REQ-003 WAIT_TIMEOUT, default 255: maximum WAIT-extended strobe cycles; 0 disables the timeout.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 cpu_rd_req / cpu_wr_req  in  1 each  level requests from the microcode sequencer; held until cpu_done or bus_err.
REQ-007 cpu_mem_io  in  1  1 = memory space, 0 = I/O space.
REQ-008 cpu_addr  in  22  physical address, already translated.
REQ-009 cpu_wdata  in  8  write data (MDR).
REQ-010 cpu_rdata  out  8  read data, valid when cpu_done is high.
REQ-011 cpu_done  out  1  one-cycle completion pulse.
REQ-012 cpu_busy  out  1  high in every state except IDLE.
REQ-013 bus_err  out  1  one-cycle pulse on WAIT timeout or illegal request.
REQ-014 addr  out  22;  data_out  out  8;  data_oe  out  1 (drives data pins);  rd, wr, mem_io  out  1 each  external bus.
REQ-015 data_in  in  8;  WAIT  in  1;  dma_req  in  1;  dma_ack  out  1.

Function
REQ-016 The SHALL use states IDLE, SETUP, STROBE, HOLD and DMA.
REQ-017 IDLE: dma_req=1 SHALL go to DMA with priority over any CPU request in the same cycle.
REQ-018 IDLE: exactly one of cpu_rd_req/cpu_wr_req high SHALL latch cpu_addr, cpu_mem_io, cpu_wdata and the direction, then go to SETUP.
REQ-019 IDLE: both requests high SHALL pulse bus_err, start no bus cycle and stay in IDLE.
REQ-020 SETUP: addr/mem_io driven from the latches, rd=wr=0, data_oe=1 for writes; stays exactly SETUP_CYCLES cycles.
REQ-021 STROBE: rd (read) or wr (write) high for at least STROBE_CYCLES cycles.
REQ-022 STROBE: once the minimum is met, WAIT=1 sampled at the edge SHALL extend STROBE by one cycle.
REQ-023 Read: data_in sampled on the last STROBE cycle SHALL be captured into cpu_rdata.
REQ-024 HOLD (one cycle): rd=wr=0, addr/mem_io/data_oe held, cpu_done=1; then IDLE.
REQ-025 Zero-wait read or write latency from the first IDLE cycle with the request seen to cpu_done SHALL be 1+SETUP_CYCLES+STROBE_CYCLES cycles (4 at defaults).
REQ-026 WAIT_TIMEOUT!=0: after WAIT_TIMEOUT consecutive extension cycles, go to HOLD with bus_err=1 instead of cpu_done; cpu_rdata unchanged.
REQ-027 The requester SHALL see no new acceptance until it deasserts the request for at least one cycle after done/err.
REQ-028 DMA: dma_ack=1, data_oe=0, rd=wr=0, addr=0, mem_io=0; dma_ack SHALL drop one cycle after dma_req=0 is sampled, then IDLE.
REQ-029 dma_req arriving mid-transaction SHALL be honoured only after HOLD; bus cycles are never interrupted.
REQ-030 Cycle counters SHALL saturate and never wrap; at least 8 bits wide.

Reset
REQ-031 On rst_n=0 at an edge, the next state SHALL be IDLE with all outputs 0: addr, data_out, data_oe, rd, wr, mem_io, dma_ack, cpu_rdata, cpu_done, cpu_busy, bus_err.
REQ-032 Reset mid-transaction or mid-DMA SHALL abandon it with no cpu_done or bus_err pulse.

Structure
REQ-033 The state enum e_biu_state SHALL live in the shared package pa_microcode alongside the control-word types.
REQ-034 The block SHALL be one module with no sub-modules; counters and FSM are inline.
REQ-035 All outputs SHALL be registered.

Verification
REQ-036 Read at defaults, addr=22'h012345, mem_io=1, data_in=8'hA5, WAIT=0: rd high for exactly 2 cycles, cpu_done at cycle 4, cpu_rdata=8'hA5.
REQ-037 Write of 8'h3C to I/O 22'h0000FF with WAIT=1 for 3 cycles after the minimum strobe: wr high 5 cycles, data_oe high SETUP through HOLD, cpu_done at cycle 7.
REQ-038 dma_req and cpu_rd_req rise together: dma_ack=1 next cycle with no rd strobe; dma_req drops and the read then completes normally.
REQ-039 WAIT stuck at 1 with WAIT_TIMEOUT=4: bus_err pulses once after 4 extension cycles, no cpu_done, then return to IDLE.
REQ-040 rst_n=0 during STROBE: all outputs 0 next cycle, no done or error pulse; a fresh request afterwards completes in 4 cycles.
REQ-041 cpu_rd_req and cpu_wr_req both high: single bus_err pulse, rd and wr stay low.

Source files
------------

// File: rtl/pa_microcode.sv
// Shared microcode types: control-word fields and bus interface unit state.
package pa_microcode;

  // Width of every BIU cycle counter; counters saturate at all-ones.
  localparam int unsigned BIU_CNT_W = 16;

  typedef logic [BIU_CNT_W-1:0] t_cnt;

  // Bus interface unit states.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSetup  = 3'd1,
    StStrobe = 3'd2,
    StHold   = 3'd3,
    StDma    = 3'd4
  } e_biu_state;

  // Bus operation field of the microcode control word.
  typedef enum logic [1:0] {
    BusNop   = 2'd0,
    BusRead  = 2'd1,
    BusWrite = 2'd2
  } e_bus_op;

  // Microcode control-word slice that drives the BIU.
  typedef struct packed {
    e_bus_op bus_op;
    logic    mem_io;
  } t_uword_bus;

  // Transaction captured when a CPU request is accepted.
  typedef struct packed {
    logic        write;
    logic        mem_io;
    logic [21:0] addr;
    logic [7:0]  wdata;
  } t_biu_req;

  // Increment that sticks at the maximum value instead of wrapping.
  function automatic t_cnt sat_inc(input t_cnt v);
    return (&v) ? v : v + t_cnt'(1);
  endfunction

endpackage

// File: rtl/bus_interface_unit.sv
// Bus interface unit: runs one external read/write bus cycle per CPU request
// (setup, strobe with WAIT extension and timeout, hold) and grants the bus to DMA.
module bus_interface_unit
  import pa_microcode::*;
#(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned WAIT_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_rd_req,
  input  logic        cpu_wr_req,
  input  logic        cpu_mem_io,
  input  logic [21:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_busy,
  output logic        bus_err,
  output logic [21:0] addr,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        rd,
  output logic        wr,
  output logic        mem_io,
  input  logic [7:0]  data_in,
  input  logic        WAIT,
  input  logic        dma_req,
  output logic        dma_ack
);

  // Zero-length phases are not meaningful; treat them as one cycle.
  localparam int unsigned SetupEff  = (SETUP_CYCLES == 0) ? 1 : SETUP_CYCLES;
  localparam int unsigned StrobeEff = (STROBE_CYCLES == 0) ? 1 : STROBE_CYCLES;

  // Counters hold cycles already completed in the current state (0 on entry).
  localparam t_cnt SetupLast  = t_cnt'(SetupEff - 1);
  localparam t_cnt StrobeLast = t_cnt'(StrobeEff - 1);
  localparam t_cnt TimeoutLim = t_cnt'(WAIT_TIMEOUT);
  localparam logic TimeoutOn  = (WAIT_TIMEOUT != 0);

  e_biu_state state_q, state_d;
  t_cnt       cnt_q, cnt_d;
  t_cnt       ext_q, ext_d;
  t_biu_req   req_q, req_d;
  logic       release_q, release_d;  // requester must drop its request first
  logic       hold_err_q, hold_err_d;  // current HOLD ends in bus_err, not done
  logic       illegal;
  logic [7:0] rdata_d;

  logic        active;
  logic [21:0] addr_d;
  logic [7:0]  data_out_d;
  logic        data_oe_d, rd_d, wr_d, mem_io_d, dma_ack_d;
  logic        done_d, busy_d, err_d;

  // Next-state, counters, request latch and read-data capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = sat_inc(cnt_q);
    ext_d      = ext_q;
    req_d      = req_q;
    release_d  = release_q;
    hold_err_d = hold_err_q;
    illegal    = 1'b0;
    rdata_d    = cpu_rdata;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        ext_d = '0;
        if (dma_req) begin
          state_d = StDma;
        end else if (release_q) begin
          if (!cpu_rd_req && !cpu_wr_req) release_d = 1'b0;
        end else if (cpu_rd_req && cpu_wr_req) begin
          illegal   = 1'b1;
          release_d = 1'b1;
        end else if (cpu_rd_req || cpu_wr_req) begin
          req_d.write  = cpu_wr_req;
          req_d.mem_io = cpu_mem_io;
          req_d.addr   = cpu_addr;
          req_d.wdata  = cpu_wdata;
          hold_err_d   = 1'b0;
          state_d      = StSetup;
        end
      end

      StSetup: begin
        if (cnt_q >= SetupLast) begin
          state_d = StStrobe;
          cnt_d   = '0;
        end
      end

      StStrobe: begin
        // Minimum strobe width first; after that WAIT extends one cycle at a time.
        if (cnt_q >= StrobeLast) begin
          if (WAIT && TimeoutOn && (ext_q >= TimeoutLim)) begin
            state_d    = StHold;
            hold_err_d = 1'b1;
            release_d  = 1'b1;
            cnt_d      = '0;
          end else if (WAIT) begin
            ext_d = sat_inc(ext_q);
          end else begin
            state_d    = StHold;
            hold_err_d = 1'b0;
            release_d  = 1'b1;
            cnt_d      = '0;
            if (!req_q.write) rdata_d = data_in;
          end
        end
      end

      StHold: begin
        state_d = StIdle;
        cnt_d   = '0;
        // A request already dropped during HOLD counts as the release cycle.
        release_d = cpu_rd_req | cpu_wr_req;
      end

      StDma: begin
        if (!dma_req) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    active     = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold);
    addr_d     = active ? req_d.addr : '0;
    mem_io_d   = active & req_d.mem_io;
    data_oe_d  = active & req_d.write;
    data_out_d = (active && req_d.write) ? req_d.wdata : '0;
    rd_d       = (state_d == StStrobe) & ~req_d.write;
    wr_d       = (state_d == StStrobe) & req_d.write;
    dma_ack_d  = (state_d == StDma);
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StHold) & ~hold_err_d;
    err_d      = ((state_d == StHold) & hold_err_d) | illegal;
  end

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ext_q      <= '0;
      req_q      <= '0;
      release_q  <= 1'b0;
      hold_err_q <= 1'b0;
      cpu_rdata  <= '0;
      cpu_done   <= 1'b0;
      cpu_busy   <= 1'b0;
      bus_err    <= 1'b0;
      addr       <= '0;
      data_out   <= '0;
      data_oe    <= 1'b0;
      rd         <= 1'b0;
      wr         <= 1'b0;
      mem_io     <= 1'b0;
      dma_ack    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ext_q      <= ext_d;
      req_q      <= req_d;
      release_q  <= release_d;
      hold_err_q <= hold_err_d;
      cpu_rdata  <= rdata_d;
      cpu_done   <= done_d;
      cpu_busy   <= busy_d;
      bus_err    <= err_d;
      addr       <= addr_d;
      data_out   <= data_out_d;
      data_oe    <= data_oe_d;
      rd         <= rd_d;
      wr         <= wr_d;
      mem_io     <= mem_io_d;
      dma_ack    <= dma_ack_d;
    end
  end

endmodule
